// File: rtl/icache_pkg.sv
// Shared types and constants for the N-way instruction cache.
package icache_pkg;

    typedef enum logic [2:0] {IDLE, REQ, FILL, DONE, INV} state_t;

    localparam logic [2:0] ARSIZE_WORD  = 3'b010;
    localparam logic [1:0] ARBURST_INCR = 2'b01;
    localparam logic [3:0] ARID_ICACHE  = 4'h0;

    // Ceiling log2; returns 0 for n <= 1.
    function automatic int log2c(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((32'sd1 <<< i) < n) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/icache_way.sv
// One cache way: valid/tag/data arrays with a combinational read port.
module icache_way
    import icache_pkg::*;
#(
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 16,
    parameter int TAG_W      = 20
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [log2c(SETS)-1:0]        rd_idx_i,
    input  logic [log2c(LINE_WORDS)-1:0]  rd_off_i,
    output logic                          rd_valid_o,
    output logic [TAG_W-1:0]              rd_tag_o,
    output logic [31:0]                   rd_data_o,
    input  logic                          wr_word_en_i,
    input  logic [log2c(SETS)-1:0]        wr_idx_i,
    input  logic [log2c(LINE_WORDS)-1:0]  wr_off_i,
    input  logic [31:0]                   wr_data_i,
    input  logic                          wr_tag_en_i,
    input  logic [TAG_W-1:0]              wr_tag_i,
    input  logic                          wr_valid_i,
    input  logic                          clr_en_i,
    input  logic [log2c(SETS)-1:0]        clr_idx_i
);

    localparam int IDX_W = log2c(SETS);
    localparam int OFF_W = log2c(LINE_WORDS);

    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [31:0]      data_q [SETS*LINE_WORDS];

    // Only valid bits need reset; tag/data are qualified by valid.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else begin
            if (clr_en_i)    valid_q[clr_idx_i] <= 1'b0;
            if (wr_tag_en_i) valid_q[wr_idx_i]  <= wr_valid_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_tag_en_i)  tag_q[wr_idx_i] <= wr_tag_i;
        if (wr_word_en_i) data_q[{wr_idx_i, wr_off_i}] <= wr_data_i;
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[{rd_idx_i, rd_off_i}];

endmodule

// File: rtl/icache_nway.sv
// N-way set-associative instruction cache: lookup, round-robin refill over AXI3, invalidate-all sweep.
module icache_nway
    import icache_pkg::*;
#(
    parameter int WAYS       = 2,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        icache_grnt,
    output logic        icache_req,
    output logic [3:0]  icache_arid,
    output logic [31:0] icache_araddr,
    output logic [3:0]  icache_arlen,
    output logic [2:0]  icache_arsize,
    output logic [1:0]  icache_arburst,
    output logic [1:0]  icache_arlock,
    output logic [3:0]  icache_arcache,
    output logic [2:0]  icache_arprot,
    output logic        icache_arvalid,
    input  logic        icache_arready,
    input  logic [3:0]  icache_rid,
    input  logic [31:0] icache_rdata,
    input  logic [1:0]  icache_rresp,
    input  logic        icache_rlast,
    input  logic        icache_rvalid,
    output logic        icache_rready,
    input  logic        cpu_re,
    input  logic [31:0] cpu_addr,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        cpu_err,
    input  logic        cpu_inv
);

    localparam int OFF_W = log2c(LINE_WORDS);
    localparam int IDX_W = log2c(SETS);
    localparam int TAG_W = 32 - IDX_W - OFF_W - 2;
    localparam int WAY_W = (WAYS > 1) ? log2c(WAYS) : 1;

    state_t           state_q;
    logic [TAG_W-1:0] mtag_q;
    logic [IDX_W-1:0] midx_q;
    logic [WAY_W-1:0] victim_q;
    logic [OFF_W-1:0] beat_q;
    logic [IDX_W-1:0] inv_cnt_q;
    logic             err_q, inv_pend_q, inv_prev_q;
    logic             req_q, arvalid_q, rready_q, cpu_err_q;
    logic [WAY_W-1:0] rr_q [SETS];
    logic [WAY_W-1:0] rr_d;

    logic [TAG_W-1:0] a_tag;
    logic [IDX_W-1:0] a_idx;
    logic [OFF_W-1:0] a_off;
    logic             hit, inv_rise, miss_go, beat_fire, last_fire, rerr, unused_ok;
    logic [IDX_W-1:0] clr_idx;

    logic [WAYS-1:0]             way_vld, way_hit;
    logic [WAYS-1:0][TAG_W-1:0]  way_tag;
    logic [WAYS-1:0][31:0]       way_data;

    assign a_tag     = cpu_addr[31 -: TAG_W];
    assign a_idx     = cpu_addr[OFF_W+2 +: IDX_W];
    assign a_off     = cpu_addr[2 +: OFF_W];
    assign unused_ok = ^{cpu_addr[1:0], icache_rid};

    assign inv_rise  = cpu_inv & ~inv_prev_q;
    assign rerr      = |icache_rresp;
    assign beat_fire = (state_q == FILL) & icache_rvalid & rready_q;
    assign last_fire = beat_fire & icache_rlast;
    assign miss_go   = (state_q == IDLE) & ~(inv_pend_q | inv_rise) & cpu_re & ~hit;
    assign clr_idx   = (state_q == INV) ? inv_cnt_q : a_idx;
    assign rr_d      = (WAYS == 1) ? '0 : rr_q[midx_q] + WAY_W'(1);

    always_comb begin
        way_hit   = '0;
        hit       = 1'b0;
        cpu_rdata = '0;
        for (int w = 0; w < WAYS; w++) begin
            way_hit[w] = way_vld[w] && (way_tag[w] == a_tag);
            hit        = hit | way_hit[w];
            if (way_hit[w]) cpu_rdata = cpu_rdata | way_data[w];
        end
    end

    // The victim is invalidated as the miss is taken so a half-written line never hits.
    for (genvar w = 0; w < WAYS; w++) begin : g_way
        icache_way #(
            .SETS       (SETS),
            .LINE_WORDS (LINE_WORDS),
            .TAG_W      (TAG_W)
        ) u_way (
            .clk_i        (clk),
            .rst_i        (rst),
            .rd_idx_i     (a_idx),
            .rd_off_i     (a_off),
            .rd_valid_o   (way_vld[w]),
            .rd_tag_o     (way_tag[w]),
            .rd_data_o    (way_data[w]),
            .wr_word_en_i (beat_fire && (victim_q == WAY_W'(w))),
            .wr_idx_i     (midx_q),
            .wr_off_i     (beat_q),
            .wr_data_i    (icache_rdata),
            .wr_tag_en_i  (last_fire && (victim_q == WAY_W'(w))),
            .wr_tag_i     (mtag_q),
            .wr_valid_i   (~(err_q | rerr)),
            .clr_en_i     ((state_q == INV) || (miss_go && (rr_q[a_idx] == WAY_W'(w)))),
            .clr_idx_i    (clr_idx)
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            mtag_q     <= '0;
            midx_q     <= '0;
            victim_q   <= '0;
            beat_q     <= '0;
            inv_cnt_q  <= '0;
            err_q      <= 1'b0;
            inv_pend_q <= 1'b0;
            inv_prev_q <= 1'b0;
            req_q      <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            cpu_err_q  <= 1'b0;
            for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
        end else begin
            inv_prev_q <= cpu_inv;
            cpu_err_q  <= 1'b0;
            if (inv_rise) inv_pend_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (inv_pend_q || inv_rise) begin
                        state_q    <= INV;
                        inv_cnt_q  <= '0;
                        inv_pend_q <= 1'b1;
                    end else if (cpu_re && !hit) begin
                        state_q   <= REQ;
                        mtag_q    <= a_tag;
                        midx_q    <= a_idx;
                        victim_q  <= rr_q[a_idx];
                        req_q     <= 1'b1;
                        arvalid_q <= icache_grnt;
                    end
                end
                REQ: begin
                    if (arvalid_q && icache_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        beat_q    <= '0;
                        state_q   <= FILL;
                    end else if (icache_grnt) begin
                        arvalid_q <= 1'b1;
                    end
                end
                FILL: begin
                    if (beat_fire) begin
                        beat_q <= beat_q + OFF_W'(1);
                        if (rerr) err_q <= 1'b1;
                        if (icache_rlast) begin
                            rready_q     <= 1'b0;
                            req_q        <= 1'b0;
                            rr_q[midx_q] <= rr_d;
                            cpu_err_q    <= err_q | rerr;
                            state_q      <= DONE;
                        end
                    end
                end
                DONE: begin
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
                INV: begin
                    inv_cnt_q <= inv_cnt_q + IDX_W'(1);
                    if (inv_cnt_q == IDX_W'(SETS - 1)) begin
                        state_q    <= IDLE;
                        inv_pend_q <= inv_rise;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cpu_stall      = (state_q != IDLE) | (cpu_re & ~hit) | inv_pend_q;
    assign cpu_err        = cpu_err_q;
    assign icache_req     = req_q;
    assign icache_arvalid = arvalid_q;
    assign icache_rready  = rready_q;
    assign icache_arid    = ARID_ICACHE;
    assign icache_araddr  = {mtag_q, midx_q, {OFF_W{1'b0}}, 2'b00};
    assign icache_arlen   = 4'(LINE_WORDS - 1);
    assign icache_arsize  = ARSIZE_WORD;
    assign icache_arburst = ARBURST_INCR;
    assign icache_arlock  = 2'b00;
    assign icache_arcache = 4'h0;
    assign icache_arprot  = 3'b000;

endmodule

// File: tb/tb_icache_nway.sv
// Directed bench for icache_nway (2 ways, 64 sets, 16-word lines) with a scripted AXI slave.
module tb_icache_nway;

    localparam int LINE_WORDS = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        icache_grnt = 1'b0;
    logic        icache_req;
    logic [3:0]  icache_arid;
    logic [31:0] icache_araddr;
    logic [3:0]  icache_arlen;
    logic [2:0]  icache_arsize;
    logic [1:0]  icache_arburst;
    logic [1:0]  icache_arlock;
    logic [3:0]  icache_arcache;
    logic [2:0]  icache_arprot;
    logic        icache_arvalid;
    logic        icache_arready = 1'b0;
    logic [3:0]  icache_rid = 4'h0;
    logic [31:0] icache_rdata = '0;
    logic [1:0]  icache_rresp = 2'b00;
    logic        icache_rlast = 1'b0;
    logic        icache_rvalid = 1'b0;
    logic        icache_rready;
    logic        cpu_re = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        cpu_err;
    logic        cpu_inv = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    icache_nway #(.WAYS(2), .SETS(64), .LINE_WORDS(LINE_WORDS)) dut (
        .clk(clk), .rst(rst), .icache_grnt(icache_grnt), .icache_req(icache_req),
        .icache_arid(icache_arid), .icache_araddr(icache_araddr), .icache_arlen(icache_arlen),
        .icache_arsize(icache_arsize), .icache_arburst(icache_arburst),
        .icache_arlock(icache_arlock), .icache_arcache(icache_arcache),
        .icache_arprot(icache_arprot), .icache_arvalid(icache_arvalid),
        .icache_arready(icache_arready), .icache_rid(icache_rid), .icache_rdata(icache_rdata),
        .icache_rresp(icache_rresp), .icache_rlast(icache_rlast), .icache_rvalid(icache_rvalid),
        .icache_rready(icache_rready), .cpu_re(cpu_re), .cpu_addr(cpu_addr),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_err(cpu_err), .cpu_inv(cpu_inv)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Combinational lookup without letting the FSM see the request.
    task automatic probe(input string tag, input logic [31:0] addr,
                         input logic exp_stall, input logic [31:0] exp_data);
        cpu_re   = 1'b1;
        cpu_addr = addr;
        #1;
        chk({tag, "_stall"}, cpu_stall, exp_stall);
        chk({tag, "_rdata"}, cpu_rdata, exp_data);
        cpu_re = 1'b0;
        #1;
    endtask

    // Issue a miss at addr and play the AXI slave; beat indices < 0 disable that event.
    task automatic fill(input logic [31:0] addr, input logic [31:0] base, input int gdly,
                        input int adly, input int err_beat, input int inv_beat,
                        input int rst_beat, input logic exp_err);
        int t;
        cpu_re   = 1'b1;
        cpu_addr = addr;
        #1;
        chk("miss_stall", cpu_stall, 1);
        t = 0;
        while (!icache_req && t < 8) begin step(); t++; end
        chk("req_up", icache_req, 1);
        for (int g = 0; g < gdly; g++) begin
            chk("arvalid_nogrant", icache_arvalid, 0);
            chk("stall_nogrant", cpu_stall, 1);
            step();
        end
        icache_grnt = 1'b1;
        t = 0;
        while (!icache_arvalid && t < 8) begin step(); t++; end
        chk("arvalid_up", icache_arvalid, 1);
        chk("araddr", icache_araddr, addr & 32'hFFFF_FFC0);
        for (int a = 0; a < adly; a++) begin
            step();
            chk("arvalid_hold", icache_arvalid, 1);
            chk("araddr_stable", icache_araddr, addr & 32'hFFFF_FFC0);
        end
        icache_arready = 1'b1;
        step();
        icache_arready = 1'b0;
        for (int i = 0; i < LINE_WORDS; i++) begin
            #1;
            chk("rready", icache_rready, 1);
            if (i == rst_beat) begin
                rst = 1'b1;
                icache_rvalid = 1'b0;
                #1;
                chk("rst_req", icache_req, 0);
                chk("rst_arvalid", icache_arvalid, 0);
                chk("rst_rready", icache_rready, 0);
                chk("rst_err", cpu_err, 0);
                chk("rst_rdata", cpu_rdata, 0);
                chk("rst_stall", cpu_stall, 1);
                return;
            end
            if (i == inv_beat) cpu_inv = 1'b1;
            icache_rvalid = 1'b1;
            icache_rdata  = base + 32'(i);
            icache_rresp  = (i == err_beat) ? 2'b10 : 2'b00;
            icache_rlast  = (i == LINE_WORDS - 1);
            step();
        end
        icache_rvalid = 1'b0;
        icache_rlast  = 1'b0;
        icache_rresp  = 2'b00;
        icache_grnt   = 1'b0;
        cpu_re        = 1'b0;
        #1;
        chk("done_err", cpu_err, exp_err);
        chk("done_req", icache_req, 0);
        chk("done_rready", icache_rready, 0);
        chk("done_stall", cpu_stall, 1);
        step();
        #1;
        chk("err_pulse_end", cpu_err, 0);
    endtask

    initial begin
        int n;
        // Reset behaviour
        #1;
        chk("rst_stall_idle", cpu_stall, 0);
        chk("rst_rdata0", cpu_rdata, 0);
        chk("rst_req0", icache_req, 0);
        cpu_re = 1'b1;
        #1;
        chk("rst_stall_re", cpu_stall, 1);
        cpu_re = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        chk("arlen", icache_arlen, 15);
        chk("arsize", icache_arsize, 3'b010);
        chk("arburst", icache_arburst, 2'b01);
        chk("arid", icache_arid, 0);

        // Cold miss then hit at another offset
        fill(32'h0000_1040, 32'hA0, 0, 0, -1, -1, -1, 1'b0);
        probe("hit_1048", 32'h0000_1048, 1'b0, 32'hA2);

        // Round robin within set 1
        fill(32'h0000_2040, 32'hB0, 0, 0, -1, -1, -1, 1'b0);
        probe("hit_2044", 32'h0000_2044, 1'b0, 32'hB1);
        probe("hit_1040", 32'h0000_1040, 1'b0, 32'hA0);
        fill(32'h0000_3040, 32'hC0, 0, 0, -1, -1, -1, 1'b0);
        probe("evict_1040", 32'h0000_1040, 1'b1, 32'h0);
        probe("keep_2040", 32'h0000_2040, 1'b0, 32'hB0);
        probe("hit_3044", 32'h0000_3044, 1'b0, 32'hC1);

        // Grant delay 5, arready delay 3; refill evicts way 1
        fill(32'h0000_1040, 32'hD0, 5, 3, -1, -1, -1, 1'b0);
        probe("refill_1048", 32'h0000_1048, 1'b0, 32'hD2);
        probe("evict_2040", 32'h0000_2040, 1'b1, 32'h0);
        probe("keep_3040", 32'h0000_3040, 1'b0, 32'hC0);

        // Error on beat 4: line stays invalid, refetch succeeds
        fill(32'h0000_4080, 32'hE0, 0, 0, 4, -1, -1, 1'b1);
        probe("err_miss", 32'h0000_4080, 1'b1, 32'h0);
        fill(32'h0000_4080, 32'hF0, 0, 0, -1, -1, -1, 1'b0);
        probe("err_refill", 32'h0000_4084, 1'b0, 32'hF1);

        // Invalidate raised during a fill
        fill(32'h0000_5000, 32'h50, 0, 0, -1, 5, -1, 1'b0);
        n = 0;
        while (cpu_stall && n < 200) begin n++; step(); #1; end
        chk("inv_cycles", n, 65);
        cpu_inv = 1'b0;
        probe("inv_5000", 32'h0000_5000, 1'b1, 32'h0);
        probe("inv_1040", 32'h0000_1040, 1'b1, 32'h0);
        probe("inv_4084", 32'h0000_4084, 1'b1, 32'h0);

        // Refill 0x4080 so reset has something to wipe, then reset mid-burst
        fill(32'h0000_4080, 32'h40, 0, 0, -1, -1, -1, 1'b0);
        probe("pre_rst_4080", 32'h0000_4080, 1'b0, 32'h40);
        fill(32'h0000_6000, 32'h60, 0, 0, -1, -1, 7, 1'b0);
        icache_grnt  = 1'b0;
        icache_rlast = 1'b0;
        icache_rresp = 2'b00;
        cpu_re       = 1'b0;
        step();
        rst = 1'b0;
        step();
        probe("rst_6000", 32'h0000_6000, 1'b1, 32'h0);
        probe("rst_4080", 32'h0000_4080, 1'b1, 32'h0);
        chk("rst_req_after", icache_req, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
